feature_prefetch_ram: RTL and testbench



---
 rtl/feat_pkg.sv | 34 +++
 rtl/feature_prefetch_ram_if.sv | 36 +++
 rtl/feat_sync_fifo.sv | 74 +++++++
 rtl/feature_prefetch_ram.sv | 238 +++++++++++++++++++++++
 tb/tb_feature_prefetch_ram.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/feat_pkg.sv
// Shared constants, state encoding and sizing helpers for the feature prefetch RAM.
package feat_pkg;

    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_ADDR_SIZE   = 32;
    localparam int DEF_LEN_WIDTH   = 10;
    localparam int DEF_QUAN_BITS   = 8;
    localparam int DEF_CH_NUM      = 3;
    localparam int DEF_BURST_LEN   = 4;
    localparam int DEF_FIFO_DEPTH  = 32;
    localparam int DEF_BASE_ADDR   = 0;
    localparam int DEF_FRAME_WORDS = 1024;
    localparam int DEF_SWAP16      = 1;

    localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_QUAN_BITS;
    localparam int CREDIT_W       = $clog2(DEF_FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } req_state_e;

    // Width able to hold any value 0..depth (occupancy or credit).
    function automatic int calc_credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Samples carried by one DDR word.
    function automatic int calc_bytes_per_word(input int data_w, input int quan_w);
        return data_w / quan_w;
    endfunction

endpackage

// File: rtl/feature_prefetch_ram_if.sv
// DDR burst-read bus plus the feature output stream of the prefetch RAM.
interface feature_prefetch_ram_if
    import feat_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int OUT_WIDTH  = DEF_CH_NUM * DEF_QUAN_BITS
);
    logic [ADDR_SIZE-1:0]  rd_burst_addr;
    logic [LEN_WIDTH-1:0]  rd_burst_len;
    logic                  rd_burst_req;
    logic [DATA_WIDTH-1:0] rd_burst_data;
    logic                  rd_burst_valid;
    logic                  rd_burst_finish;
    logic [OUT_WIDTH-1:0]  o_feature_data;
    logic                  o_f_data_valid;
    logic                  o_frame_done;
    logic                  i_data_ready;

    // Prefetch block side: issues bursts, produces feature beats.
    modport master (
        output rd_burst_addr, rd_burst_len, rd_burst_req,
        input  rd_burst_data, rd_burst_valid, rd_burst_finish,
        output o_feature_data, o_f_data_valid, o_frame_done,
        input  i_data_ready
    );

    // Environment side: DDR controller and feature consumer.
    modport slave (
        input  rd_burst_addr, rd_burst_len, rd_burst_req,
        output rd_burst_data, rd_burst_valid, rd_burst_finish,
        input  o_feature_data, o_f_data_valid, o_frame_done,
        output i_data_ready
    );
endinterface

// File: rtl/feat_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush.
module feat_sync_fifo
    import feat_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok_s, rd_ok_s;

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == {CW{1'b0}});
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;

    // Pointer and occupancy update; flush wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_ok_s  = wr_en && !full && !flush;
        rd_ok_s  = rd_en && !empty && !flush;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (wr_ok_s) wr_ptr_d = wr_ptr_q + AW'(1);
            else         wr_ptr_d = wr_ptr_q;
            if (rd_ok_s) rd_ptr_d = rd_ptr_q + AW'(1);
            else         rd_ptr_d = rd_ptr_q;
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (wr_ok_s) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/feature_prefetch_ram.sv
// Credit-limited DDR burst prefetcher that unpacks words into CH_NUM-sample beats.
module feature_prefetch_ram
    import feat_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int QUAN_BITS   = DEF_QUAN_BITS,
    parameter int CH_NUM      = DEF_CH_NUM,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int SWAP16      = DEF_SWAP16
)(
    input  logic                   s_clk,
    input  logic                   s_rst,
    input  logic                   i_frame_restart,
    feature_prefetch_ram_if.master bus
);
    localparam int BPW         = calc_bytes_per_word(DATA_WIDTH, QUAN_BITS);
    localparam int CW          = calc_credit_w(FIFO_DEPTH);
    localparam int WORD_BYTES  = DATA_WIDTH / 8;
    localparam int LANES       = DATA_WIDTH / 16;
    localparam int CAP         = BPW + CH_NUM - 1;
    localparam int BUF_W       = CAP * QUAN_BITS;
    localparam int SCNT_W      = $clog2(CAP + 1);
    localparam int OUT_W       = CH_NUM * QUAN_BITS;
    localparam int TOTAL_BEATS = FRAME_WORDS * BPW / CH_NUM;
    localparam int BEAT_W      = $clog2(TOTAL_BEATS + 1);
    localparam int REM_W       = $clog2(FRAME_WORDS + 1);

    if (((FRAME_WORDS * BPW) % CH_NUM) != 0) begin : g_bad_frame
        $error("FRAME_WORDS*DATA_WIDTH/QUAN_BITS must be a multiple of CH_NUM");
    end
    if ((CH_NUM < 1) || (CH_NUM > 8)) begin : g_bad_ch
        $error("CH_NUM must lie in 1..8");
    end
    if ((FIFO_DEPTH < 2 * BURST_LEN) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2*BURST_LEN");
    end

    req_state_e            state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic                  discard_q, discard_d;
    logic [CW-1:0]         credit_s;
    int                    len_int_s;

    logic                  fifo_wr_s, fifo_rd_s, fifo_full_s, fifo_empty_s;
    logic [CW-1:0]         fifo_count_s;
    logic [DATA_WIDTH-1:0] fifo_rd_data_s, head_swapped_s;

    logic [BUF_W-1:0]      buf_q, buf_d, buf_after_s;
    logic [SCNT_W-1:0]     scnt_q, scnt_d, scnt_after_s;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_W-1:0]      out_data_q, out_data_d;
    logic                  last_q, last_d;
    logic                  take_s, load_s;

    feat_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(s_clk), .rst(s_rst), .flush(i_frame_restart),
        .wr_en(fifo_wr_s), .wr_data(bus.rd_burst_data),
        .rd_en(fifo_rd_s), .rd_data(fifo_rd_data_s),
        .empty(fifo_empty_s), .full(fifo_full_s), .count(fifo_count_s)
    );

    if (SWAP16 != 0) begin : g_swap
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign head_swapped_s[16*l +: 16] = fifo_rd_data_s[16*(LANES-1-l) +: 16];
        end
    end else begin : g_noswap
        assign head_swapped_s = fifo_rd_data_s;
    end

    // Burst request FSM with credit accounting and post-restart discard.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rem_d     = rem_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        credit_s  = fifo_count_s + outst_q;
        len_int_s = (int'(rem_q) < BURST_LEN) ? int'(rem_q) : BURST_LEN;
        fifo_wr_s = bus.rd_burst_valid && (state_q == ST_REQ) && !discard_q && !i_frame_restart;
        if (fifo_wr_s) outst_d = outst_q - CW'(1);
        else           outst_d = outst_q;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_restart) begin
                    state_d = ST_IDLE;
                end else if (rem_q == {REM_W{1'b0}}) begin
                    state_d = ST_DONE;
                end else if ((FIFO_DEPTH - int'(credit_s)) >= len_int_s) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    len_d   = LEN_WIDTH'(len_int_s);
                    outst_d = outst_q + CW'(len_int_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.rd_burst_finish) begin
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    discard_d = 1'b0;
                    if (!discard_q) begin
                        addr_d = addr_q + ADDR_SIZE'(int'(len_q) * WORD_BYTES);
                        rem_d  = rem_q - REM_W'(len_q);
                    end else begin
                        addr_d = addr_q;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                if (i_frame_restart) state_d = ST_IDLE;
                else                 state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
        if (i_frame_restart) begin
            rem_d   = REM_W'(FRAME_WORDS);
            addr_d  = ADDR_SIZE'(BASE_ADDR);
            outst_d = {CW{1'b0}};
            if ((state_q == ST_REQ) && !bus.rd_burst_finish) discard_d = 1'b1;
            else                                               discard_d = 1'b0;
        end else begin
            discard_d = discard_d;
        end
    end

    // Request-side registers.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            addr_q    <= ADDR_SIZE'(BASE_ADDR);
            len_q     <= LEN_WIDTH'(BURST_LEN);
            rem_q     <= REM_W'(FRAME_WORDS);
            outst_q   <= {CW{1'b0}};
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    // Sample unpacker: emit a beat when CH_NUM samples wait, refill from the FIFO head.
    always_comb begin
        take_s = !out_valid_q || bus.i_data_ready;
        load_s = take_s && (int'(scnt_q) >= CH_NUM) && (int'(beat_q) < TOTAL_BEATS);
        if (load_s) begin
            scnt_after_s = scnt_q - SCNT_W'(CH_NUM);
            buf_after_s  = buf_q >> OUT_W;
        end else begin
            scnt_after_s = scnt_q;
            buf_after_s  = buf_q;
        end
        fifo_rd_s = !fifo_empty_s && !i_frame_restart && ((int'(scnt_after_s) + BPW) <= CAP);
        buf_d  = buf_after_s;
        scnt_d = scnt_after_s;
        if (fifo_rd_s) begin
            buf_d  = buf_after_s | (BUF_W'(head_swapped_s) << (int'(scnt_after_s) * QUAN_BITS));
            scnt_d = scnt_after_s + SCNT_W'(BPW);
        end else begin
            scnt_d = scnt_after_s;
        end
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        last_d      = last_q;
        beat_d      = beat_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = buf_q[OUT_W-1:0];
            last_d      = (beat_q == BEAT_W'(TOTAL_BEATS - 1));
            beat_d      = beat_q + BEAT_W'(1);
        end else if (out_valid_q && bus.i_data_ready) begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (i_frame_restart) begin
            buf_d       = {BUF_W{1'b0}};
            scnt_d      = {SCNT_W{1'b0}};
            beat_d      = {BEAT_W{1'b0}};
            out_valid_d = 1'b0;
            out_data_d  = {OUT_W{1'b0}};
            last_d      = 1'b0;
        end else begin
            beat_d = beat_d;
        end
    end

    // Unpacker and output registers.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            buf_q       <= {BUF_W{1'b0}};
            scnt_q      <= {SCNT_W{1'b0}};
            beat_q      <= {BEAT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
            last_q      <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            scnt_q      <= scnt_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
        end
    end

    assign bus.rd_burst_addr  = addr_q;
    assign bus.rd_burst_len   = len_q;
    assign bus.rd_burst_req   = req_q;
    assign bus.o_feature_data = out_data_q;
    assign bus.o_f_data_valid = out_valid_q;
    // Final beat is flagged when loaded; the pulse coincides with its handshake.
    assign bus.o_frame_done   = out_valid_q && last_q && bus.i_data_ready;
endmodule

// File: tb/tb_feature_prefetch_ram.sv
// Randomised bench: DDR responder, ready driver and a sample-level reference model.
module tb_feature_prefetch_ram;
    import feat_pkg::*;

    localparam int FW    = 42;
    localparam int TOTAL = FW * 8 / 3;

    logic        s_clk = 1'b0;
    logic        s_rst;
    logic        restart;
    logic [63:0] mem [FW];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          burst_cnt = 0;
    int          restart_gen = 0;
    int          ready_mode = 1;
    logic        chk_drop = 1'b0;

    feature_prefetch_ram_if #(.DATA_WIDTH(64), .ADDR_SIZE(32), .LEN_WIDTH(10), .OUT_WIDTH(24)) bus_if ();

    feature_prefetch_ram #(.FRAME_WORDS(FW)) dut (
        .s_clk(s_clk), .s_rst(s_rst), .i_frame_restart(restart), .bus(bus_if)
    );

    always #5 s_clk = ~s_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Sample s of the frame: swapped-lane byte order, LSB first.
    function automatic logic [7:0] exp_sample(input int s);
        logic [63:0] w;
        int j, src;
        w   = mem[s / 8];
        j   = s % 8;
        src = (3 - j / 2) * 2 + (j % 2);
        return w[src*8 +: 8];
    endfunction

    function automatic logic [23:0] exp_beat(input int b);
        return {exp_sample(3*b + 2), exp_sample(3*b + 1), exp_sample(3*b)};
    endfunction

    task automatic regen_mem();
        for (int i = 0; i < FW; i++) mem[i] = {$urandom, $urandom};
    endtask

    task automatic pulse_restart();
        @(posedge s_clk); #1;
        restart = 1'b1;
        restart_gen++;
        @(posedge s_clk); #1;
        restart = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while ((done_cnt < target) && (n < budget)) begin
            @(negedge s_clk);
            n++;
        end
        chk("frame_done_count", 64'(done_cnt), 64'(target));
    endtask

    // Consumer ready: 0 = held low, 1 = held high, other = 30% back-pressure.
    initial begin
        bus_if.i_data_ready = 1'b0;
        forever begin
            @(posedge s_clk); #1;
            case (ready_mode)
                0:       bus_if.i_data_ready = 1'b0;
                1:       bus_if.i_data_ready = 1'b1;
                default: bus_if.i_data_ready = ($urandom_range(0, 99) >= 30);
            endcase
        end
    end

    // DDR responder with its own expectation of the burst address sequence.
    initial begin
        int a, n, ex_len, exp_words, seen_gen, gen_at_grant;
        bus_if.rd_burst_valid  = 1'b0;
        bus_if.rd_burst_finish = 1'b0;
        bus_if.rd_burst_data   = 64'd0;
        exp_words = 0;
        seen_gen  = 0;
        forever begin
            @(negedge s_clk);
            if ((bus_if.rd_burst_req === 1'b1) && !s_rst) begin
                if (restart_gen != seen_gen) begin
                    exp_words = 0;
                    seen_gen  = restart_gen;
                end
                gen_at_grant = restart_gen;
                a      = int'(bus_if.rd_burst_addr);
                n      = int'(bus_if.rd_burst_len);
                ex_len = ((FW - exp_words) < 4) ? (FW - exp_words) : 4;
                chk("burst_addr", 64'(a), 64'(exp_words * 8));
                chk("burst_len", 64'(n), 64'(ex_len));
                burst_cnt++;
                if (n > 16) n = 16;
                repeat ($urandom_range(0, 2)) @(posedge s_clk);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge s_clk); #1;
                        bus_if.rd_burst_valid = 1'b0;
                    end
                    @(posedge s_clk); #1;
                    chk("burst_hold", 64'({bus_if.rd_burst_req, bus_if.rd_burst_addr, 22'(bus_if.rd_burst_len)}),
                        64'({1'b1, 32'(a), 22'(n)}));
                    bus_if.rd_burst_valid = 1'b1;
                    bus_if.rd_burst_data  = mem[((a / 8) + i) % FW];
                end
                @(posedge s_clk); #1;
                bus_if.rd_burst_valid  = 1'b0;
                bus_if.rd_burst_finish = 1'b1;
                @(posedge s_clk); #1;
                bus_if.rd_burst_finish = 1'b0;
                chk("req_drop", 64'(bus_if.rd_burst_req), 64'd0);
                if (restart_gen == gen_at_grant) exp_words = exp_words + n;
            end
        end
    end

    // Output monitor against the sample-level model.
    initial begin
        int          beat_idx;
        logic        pend;
        logic [23:0] pdata;
        beat_idx = 0;
        pend     = 1'b0;
        pdata    = 24'd0;
        forever begin
            @(negedge s_clk);
            if (s_rst) begin
                beat_idx = 0;
                pend     = 1'b0;
            end else if (restart) begin
                beat_idx = 0;
                pend     = 1'b0;
                chk_drop = 1'b1;
            end else begin
                if (chk_drop) begin
                    chk("restart_drop_valid", 64'(bus_if.o_f_data_valid), 64'd0);
                    chk_drop = 1'b0;
                end
                if (dut.fifo_wr_s) chk("fifo_overflow", 64'(dut.fifo_full_s), 64'd0);
                if (pend) begin
                    chk("hold_valid", 64'(bus_if.o_f_data_valid), 64'd1);
                    chk("hold_data", 64'(bus_if.o_feature_data), 64'(pdata));
                end
                if (bus_if.o_frame_done && !(bus_if.o_f_data_valid && bus_if.i_data_ready))
                    chk("done_without_hs", 64'(bus_if.o_frame_done), 64'd0);
                if (bus_if.o_f_data_valid && bus_if.i_data_ready) begin
                    if (beat_idx >= TOTAL) begin
                        chk("extra_beat", 64'(beat_idx), 64'(TOTAL - 1));
                    end else begin
                        chk("beat_data", 64'(bus_if.o_feature_data), 64'(exp_beat(beat_idx)));
                        if ((restart_gen == 0) && (beat_idx == 0))
                            chk("swap16_first_beat", 64'(bus_if.o_feature_data), 64'h040706);
                    end
                    chk("frame_done", 64'(bus_if.o_frame_done), 64'(beat_idx == TOTAL - 1));
                    if (bus_if.o_frame_done) done_cnt++;
                    beat_idx++;
                end
                pend  = bus_if.o_f_data_valid && !bus_if.i_data_ready;
                pdata = bus_if.o_feature_data;
            end
        end
    end

    // Scenario sequencer.
    initial begin
        int b0, n;
        s_rst   = 1'b1;
        restart = 1'b0;
        regen_mem();
        mem[0] = 64'h0706050403020100;
        repeat (3) @(posedge s_clk);
        @(negedge s_clk);
        chk("rst_req", 64'(bus_if.rd_burst_req), 64'd0);
        chk("rst_addr", 64'(bus_if.rd_burst_addr), 64'd0);
        chk("rst_len", 64'(bus_if.rd_burst_len), 64'd4);
        chk("rst_valid", 64'(bus_if.o_f_data_valid), 64'd0);
        chk("rst_data", 64'(bus_if.o_feature_data), 64'd0);
        chk("rst_done", 64'(bus_if.o_frame_done), 64'd0);
        @(posedge s_clk); #1;
        s_rst = 1'b0;

        // Frame 1: random back-pressure, ten full bursts plus a truncated one.
        ready_mode = 2;
        wait_done(1, 4000);
        repeat (20) @(negedge s_clk);
        chk("done_no_req", 64'(bus_if.rd_burst_req), 64'd0);
        chk("frame1_bursts", 64'(burst_cnt), 64'd11);

        // Frame 2: ready held low caps credit at the FIFO depth.
        regen_mem();
        ready_mode = 0;
        b0 = burst_cnt;
        pulse_restart();
        repeat (300) @(negedge s_clk);
        chk("bp_bursts", 64'(burst_cnt - b0), 64'd8);
        chk("bp_req_idle", 64'(bus_if.rd_burst_req), 64'd0);
        chk("bp_valid_held", 64'(bus_if.o_f_data_valid), 64'd1);
        ready_mode = 2;
        wait_done(2, 4000);

        // Frame 3: restart again shortly after a grant, mid-burst.
        regen_mem();
        ready_mode = 1;
        pulse_restart();
        n = 0;
        while ((bus_if.rd_burst_req !== 1'b1) && (n < 50)) begin
            @(negedge s_clk);
            n++;
        end
        chk("grant_seen", 64'(bus_if.rd_burst_req), 64'd1);
        repeat (2) @(posedge s_clk);
        pulse_restart();
        chk("req_hold_discard", 64'(bus_if.rd_burst_req), 64'd1);
        wait_done(3, 4000);
        repeat (30) @(negedge s_clk);
        chk("total_done_pulses", 64'(done_cnt), 64'd3);
        chk("final_no_req", 64'(bus_if.rd_burst_req), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
